// File: rtl/multiplier_leak_monitor.sv
// Parallel shift-add multiplier copies plus a monitor that flags whether the
// copies finished in different cycles, a timing side channel on the operands.
module multiplier_leak_monitor #(
  parameter int WIDTH      = 4,
  parameter int NCOPIES    = 2,
  parameter int EARLY_EXIT = 0,
  localparam int SKEW_W    = $clog2(WIDTH + 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NCOPIES*WIDTH-1:0]     multiplier,
  input  logic [NCOPIES*WIDTH-1:0]     multiplicand,
  output logic [NCOPIES*2*WIDTH-1:0]   product,
  output logic [NCOPIES-1:0]           productDone,
  output logic                         busy,
  output logic                         timingLeakDone,
  output logic                         timingLeak,
  output logic [SKEW_W-1:0]            skewCycles
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {C_IDLE, C_CALC, C_DONE} copy_state_e;
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_REPORT} mon_state_e;

  // Handshake: a start is accepted on any edge where the monitor is not in RUN
  // (busy=0); starts seen while busy=1 are dropped without touching any state.
  mon_state_e        mon_state_q, mon_state_d;
  logic              leak_done_q, leak_done_d;
  logic              leak_q, leak_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic              accept;

  assign accept = start && (mon_state_q != M_RUN);

  for (genvar k = 0; k < NCOPIES; k++) begin : g_copy
    copy_state_e        state_q, state_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] mcnd_q, mcnd_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               finish;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= C_IDLE;
        mplr_q  <= '0;
        mcnd_q  <= '0;
        prod_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        mplr_q  <= mplr_d;
        mcnd_q  <= mcnd_d;
        prod_q  <= prod_d;
        cnt_q   <= cnt_d;
      end
    end

    // Early exit stops once the remaining multiplier bits are all zero (after
    // at least one step); constant-time always runs the full WIDTH steps.
    always_comb begin
      state_d = state_q;
      mplr_d  = mplr_q;
      mcnd_d  = mcnd_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      if (EARLY_EXIT != 0) finish = (cnt_q != '0) && (mplr_q == '0);
      else                 finish = (cnt_q == CNT_W'(WIDTH));
      if (accept) begin
        state_d = C_CALC;
        mplr_d  = multiplier[k*WIDTH +: WIDTH];
        mcnd_d  = {{WIDTH{1'b0}}, multiplicand[k*WIDTH +: WIDTH]};
        prod_d  = '0;
        cnt_d   = '0;
      end else if (state_q == C_CALC) begin
        if (finish) begin
          state_d = C_DONE;
        end else begin
          if (mplr_q[0]) prod_d = prod_q + mcnd_q;
          mplr_d = mplr_q >> 1;
          mcnd_d = mcnd_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
    end

    assign product[k*2*WIDTH +: 2*WIDTH] = prod_q;
    assign productDone[k]                = (state_q == C_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mon_state_q <= M_IDLE;
      leak_done_q <= 1'b0;
      leak_q      <= 1'b0;
      skew_q      <= '0;
    end else begin
      mon_state_q <= mon_state_d;
      leak_done_q <= leak_done_d;
      leak_q      <= leak_d;
      skew_q      <= skew_d;
    end
  end

  // Flags sample the registered done bits, so they trail completion by one edge.
  always_comb begin
    mon_state_d = mon_state_q;
    leak_done_d = leak_done_q;
    leak_d      = leak_q;
    skew_d      = skew_q;
    if (accept) begin
      mon_state_d = M_RUN;
      leak_done_d = 1'b0;
      leak_d      = 1'b0;
      skew_d      = '0;
    end else if (mon_state_q == M_RUN) begin
      if (|productDone) leak_done_d = 1'b1;
      if ((|productDone) && !(&productDone)) begin
        leak_d = 1'b1;
        if (skew_q != '1) skew_d = skew_q + SKEW_W'(1);
      end
      if (&productDone) mon_state_d = M_REPORT;
    end
  end

  assign busy           = (mon_state_q == M_RUN);
  assign timingLeakDone = leak_done_q;
  assign timingLeak     = leak_q;
  assign skewCycles     = skew_q;

endmodule

// File: tb/tb_multiplier_leak_monitor.sv
// Drives a constant-time and an early-exit instance with identical operands and
// scores each completed run against a cycle-level arithmetic model.
module tb_multiplier_leak_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] multiplier = '0;
  logic [7:0] multiplicand = '0;

  logic [15:0] prod_w [2];
  logic [1:0]  done_w [2];
  logic        busy_w [2];
  logic        tld_w  [2];
  logic        tl_w   [2];
  logic [2:0]  skew_w [2];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int prod0; int prod1; int dc0; int dc1;
    int busy_low; int skew; int tl; int tldr; int tlr;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  always #5 clk = ~clk;

  multiplier_leak_monitor #(.WIDTH(4), .NCOPIES(2), .EARLY_EXIT(0)) u_ct (
    .clk(clk), .rst(rst), .start(start), .multiplier(multiplier),
    .multiplicand(multiplicand), .product(prod_w[0]), .productDone(done_w[0]),
    .busy(busy_w[0]), .timingLeakDone(tld_w[0]), .timingLeak(tl_w[0]),
    .skewCycles(skew_w[0]));

  multiplier_leak_monitor #(.WIDTH(4), .NCOPIES(2), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst(rst), .start(start), .multiplier(multiplier),
    .multiplicand(multiplicand), .product(prod_w[1]), .productDone(done_w[1]),
    .busy(busy_w[1]), .timingLeakDone(tld_w[1]), .timingLeak(tl_w[1]),
    .skewCycles(skew_w[1]));

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Reference: a copy needs ncalc steps and is done one cycle later; every
  // cycle between the first and last done counts as skew.
  function automatic int ncalc(input int ee, input int a);
    if (ee == 0) return 4;
    return (a < 2) ? 1 : $clog2(a + 1);
  endfunction

  function automatic exp_t model(input int ee, input int a0, input int b0,
                                 input int a1, input int b1);
    exp_t e;
    int mx, mn;
    e.prod0 = a0 * b0;
    e.prod1 = a1 * b1;
    e.dc0 = ncalc(ee, a0) + 1;
    e.dc1 = ncalc(ee, a1) + 1;
    mx = (e.dc0 > e.dc1) ? e.dc0 : e.dc1;
    mn = (e.dc0 < e.dc1) ? e.dc0 : e.dc1;
    e.busy_low = mx + 1;
    e.skew = (mx - mn > 7) ? 7 : mx - mn;
    e.tl = (mx != mn) ? 1 : 0;
    e.tldr = mn + 1;
    e.tlr = (mx != mn) ? mn + 1 : -1;
    return e;
  endfunction

  // Monitor state, per DUT
  bit in_run [2];
  bit prev_busy [2];
  int t [2];
  int dc [2][2];
  int tldr [2];
  int tlr [2];

  task automatic finish_run(input int d);
    exp_t e;
    int qs;
    qs = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (qs == 0) begin
      chk($sformatf("d%0d_unexpected_run", d), 1, 0);
      return;
    end
    if (d == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    chk($sformatf("d%0d_prod0", d), int'(prod_w[d][7:0]), e.prod0);
    chk($sformatf("d%0d_prod1", d), int'(prod_w[d][15:8]), e.prod1);
    chk($sformatf("d%0d_done0_cycle", d), dc[d][0], e.dc0);
    chk($sformatf("d%0d_done1_cycle", d), dc[d][1], e.dc1);
    chk($sformatf("d%0d_busy_low_cycle", d), t[d], e.busy_low);
    chk($sformatf("d%0d_skew", d), int'(skew_w[d]), e.skew);
    chk($sformatf("d%0d_leak", d), int'(tl_w[d]), e.tl);
    chk($sformatf("d%0d_leak_done", d), int'(tld_w[d]), 1);
    chk($sformatf("d%0d_leak_done_rise", d), tldr[d], e.tldr);
    chk($sformatf("d%0d_leak_rise", d), tlr[d], e.tlr);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        in_run[d] = 1'b0;
        prev_busy[d] = 1'b0;
      end else begin
        if (busy_w[d] && !prev_busy[d]) begin
          in_run[d] = 1'b1;
          t[d] = 0;
          dc[d][0] = -1;
          dc[d][1] = -1;
          tldr[d] = -1;
          tlr[d] = -1;
        end else if (in_run[d]) begin
          t[d]++;
        end
        if (in_run[d]) begin
          for (int c = 0; c < 2; c++)
            if (done_w[d][c] && dc[d][c] < 0) dc[d][c] = t[d];
          if (tld_w[d] && tldr[d] < 0) tldr[d] = t[d];
          if (tl_w[d] && tlr[d] < 0) tlr[d] = t[d];
          if (!busy_w[d] && prev_busy[d]) begin
            finish_run(d);
            in_run[d] = 1'b0;
          end
        end
        prev_busy[d] = busy_w[d];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_product", tag, d), int'(prod_w[d]), 0);
      chk($sformatf("%s_d%0d_done", tag, d), int'(done_w[d]), 0);
      chk($sformatf("%s_d%0d_busy", tag, d), int'(busy_w[d]), 0);
      chk($sformatf("%s_d%0d_leak_done", tag, d), int'(tld_w[d]), 0);
      chk($sformatf("%s_d%0d_leak", tag, d), int'(tl_w[d]), 0);
      chk($sformatf("%s_d%0d_skew", tag, d), int'(skew_w[d]), 0);
    end
  endtask

  task automatic wait_idle();
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      tick();
      if (exp_q0.size() == 0 && exp_q1.size() == 0) drained = 1'b1;
    end
    chk("run_completion", exp_q0.size() + exp_q1.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Called just after a negedge; start is sampled by the following posedge.
  task automatic do_run(input int a0, input int b0, input int a1, input int b1,
                        input bit extra);
    multiplier   = {4'(a1), 4'(a0)};
    multiplicand = {4'(b1), 4'(b0)};
    start = 1'b1;
    exp_q0.push_back(model(0, a0, b0, a1, b1));
    exp_q1.push_back(model(1, a0, b0, a1, b1));
    tick();
    start = 1'b0;
    multiplier   = 8'($urandom);
    multiplicand = 8'($urandom);
    if (extra) begin
      tick();
      start = 1'b1;
      multiplier   = 8'($urandom);
      multiplicand = 8'($urandom);
      tick();
      start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;

    do_run(3, 5, 15, 15, 1'b0);
    do_run(1, 7, 8, 3, 1'b0);
    do_run(0, 9, 0, 9, 1'b0);
    do_run(1, 7, 8, 3, 1'b1);

    // Reset mid-run, then a fresh start at cycle 6
    multiplier = 8'h8F;
    multiplicand = 8'hB6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_zero("abort");
    rst = 1'b0;
    tick();
    chk("abort_no_done_d0", int'(done_w[0]), 0);
    chk("abort_no_done_d1", int'(done_w[1]), 0);
    do_run(6, 11, 2, 13, 1'b0);

    // Start and reset together: reset wins
    rst = 1'b1;
    start = 1'b1;
    tick();
    check_zero("rst_and_start");
    rst = 1'b0;
    start = 1'b0;
    tick();

    for (int i = 0; i < 24; i++)
      do_run($urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15), (i % 4) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
